// File: rtl/simmem_pkg.sv
// Shared simulated-memory types: AW/W/B payloads and the AW metadata kept by
// the write-response generator.
package simmem_pkg;

  localparam int unsigned IdWidth      = 8;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned AxLenWidth   = 8;
  localparam int unsigned AxSizeWidth  = 3;
  localparam int unsigned AxBurstWidth = 2;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned StrbWidth    = DataWidth / 8;

  localparam logic WRESP_OKAY   = 1'b0;
  localparam logic WRESP_SLVERR = 1'b1;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [AddrWidth-1:0]    addr;
    logic [AxLenWidth-1:0]   burst_length;
    logic [AxSizeWidth-1:0]  burst_size;
    logic [AxBurstWidth-1:0] burst_type;
  } write_addr_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } write_data_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               rsp;
  } write_resp_t;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [AxLenWidth-1:0] burst_length;
  } aw_meta_t;

  localparam int unsigned AwMetaWidth = $bits(aw_meta_t);

  // Extract the fields the response path needs from an AW request.
  function automatic aw_meta_t aw_meta_from_req(input write_addr_req_t req);
    aw_meta_t meta;
    meta.id           = req.id;
    meta.burst_length = req.burst_length;
    return meta;
  endfunction

endpackage

// File: rtl/simmem_wresp_fifo.sv
// Generic synchronous FIFO with registered count; head is the oldest entry.
module simmem_wresp_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy update; pointers wrap at their natural width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CntWidth'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CntWidth'(1);
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are meaningless while the entry is not occupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/simmem_wresp_gen.sv
// Write-response generator: pairs W bursts with queued AW requests in order
// and emits one B response per completed burst through a single output stage.
// Optional burst-length checking is enabled by SIMMEM_WRESP_LEN_CHECK_EN.
module simmem_wresp_gen
  import simmem_pkg::*;
#(
  parameter int unsigned AwFifoDepth = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [$bits(write_addr_req_t)-1:0] waddr_i,
  input  logic                            waddr_valid_i,
  output logic                            waddr_ready_o,
  input  logic [$bits(write_data_req_t)-1:0] wdata_i,
  input  logic                            wdata_valid_i,
  output logic                            wdata_ready_o,
  output logic [$bits(write_resp_t)-1:0]  wresp_o,
  output logic                            wresp_valid_o,
  input  logic                            wresp_ready_i
);

  write_addr_req_t waddr;
  write_data_req_t wdata;
  aw_meta_t        head;
  logic [AwMetaWidth-1:0] head_raw;
  logic            fifo_full, fifo_empty;
  logic            aw_push, w_hs, last_hs;
  logic            resp_code;

  logic [AxLenWidth-1:0] cnt_q, cnt_d;
  write_resp_t           resp_q, resp_d;
  logic                  resp_valid_q, resp_valid_d;

  assign waddr = write_addr_req_t'(waddr_i);
  assign wdata = write_data_req_t'(wdata_i);
  assign head  = aw_meta_t'(head_raw);

  assign waddr_ready_o = !fifo_full;
  assign aw_push       = waddr_valid_i && waddr_ready_o;
  assign wdata_ready_o = !fifo_empty && (!resp_valid_q || wresp_ready_i);
  assign w_hs          = wdata_valid_i && wdata_ready_o;
  assign last_hs       = w_hs && wdata.last;

  assign wresp_o       = resp_q;
  assign wresp_valid_o = resp_valid_q;

  simmem_wresp_fifo #(
    .Width (AwMetaWidth),
    .Depth (AwFifoDepth)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_push),
    .data_i  (aw_meta_from_req(waddr)),
    .pop_i   (last_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

`ifdef SIMMEM_WRESP_LEN_CHECK_EN
  logic err_q, err_d, len_err;

  // Beat-count mismatch against the head AW length, sticky within a burst.
  always_comb begin
    len_err = 1'b0;
    if (w_hs) begin
      if (wdata.last) len_err = (cnt_q != head.burst_length);
      else            len_err = (cnt_q == head.burst_length);
    end
    err_d = err_q;
    if (last_hs)      err_d = 1'b0;
    else if (len_err) err_d = 1'b1;
    resp_code = (err_q || len_err) ? WRESP_SLVERR : WRESP_OKAY;
  end

  // Error flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  logic unused_fields;
  assign unused_fields = ^{waddr.addr, waddr.burst_size, waddr.burst_type,
                           wdata.id, wdata.data, wdata.strb};
`else
  assign resp_code = WRESP_OKAY;

  logic unused_fields;
  assign unused_fields = ^{waddr.addr, waddr.burst_size, waddr.burst_type,
                           wdata.id, wdata.data, wdata.strb,
                           head.burst_length, cnt_q};
`endif

  // Beat counter and output-stage next state.
  always_comb begin
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;

    if (last_hs)                          cnt_d = '0;
    else if (w_hs && (cnt_q != '1))       cnt_d = cnt_q + AxLenWidth'(1);

    if (resp_valid_q && wresp_ready_i) begin
      resp_valid_d = 1'b0;
      resp_d       = '0;
    end
    if (last_hs) begin
      resp_valid_d = 1'b1;
      resp_d.id    = head.id;
      resp_d.rsp   = resp_code;
    end
  end

  // Beat counter and response register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: doc/simmem_wresp_gen.md
Name: simmem_wresp_gen

Overview:
- Write-response responder on the simulated-memory slave side.
- Accepts write address requests (write_addr_req_t) and write data beats (write_data_req_t).
- Emits exactly one write_resp_t per completed burst, carrying the burst's AW id, in AW acceptance order.
- Produces the B channel that the delay/reorder logic later holds back.

Parameters:
- AwFifoDepth, 4, number of outstanding accepted AW requests awaiting their data; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- waddr_i  in  $bits(write_addr_req_t)  write address request
- waddr_valid_i  in  1  AW valid
- waddr_ready_o  out  1  AW ready
- wdata_i  in  $bits(write_data_req_t)  write data beat
- wdata_valid_i  in  1  W valid
- wdata_ready_o  out  1  W ready
- wresp_o  out  $bits(write_resp_t)  write response
- wresp_valid_o  out  1  B valid
- wresp_ready_i  in  1  B ready

Behaviour:
- Reset is synchronous, active-high: the clock edge with rst_i=1 clears all state.
  - AW FIFO empty; beat counter 0; error flag 0; output register empty.
  - wresp_valid_o=0, wresp_o='0.
  - waddr_ready_o=1 in the cycle after reset.
- Reset mid-burst discards all outstanding AW entries and partial bursts. No response is emitted for them.
- AW FIFO:
  - Stores aw_meta_t {id, burst_length} per entry.
  - waddr_ready_o = !full; the signal is not combinationally dependent on pop.
  - Push on waddr_valid_i && waddr_ready_o.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers are log2(AwFifoDepth) bits and wrap naturally. Count is one bit wider.
- W acceptance:
  - wdata_ready_o = fifo_nonempty && (!wresp_valid_o || wresp_ready_i).
  - No bypass: an AW pushed in cycle N can pair with a W beat no earlier than cycle N+1.
  - wdata_i.id is ignored.
  - A beat handshake is wdata_valid_i && wdata_ready_o.
- Beat counter (AxLenWidth bits):
  - Increments on each non-last beat, saturating at 2^AxLenWidth-1.
  - Returns to 0 on a last beat.
- Burst completion, on the handshake of a beat with last=1:
  - The AW head is popped.
  - The output register loads id=head.id and response per the Optional Feature.
  - wresp_valid_o rises the next cycle. Latency from last-beat handshake to valid is 1 cycle.
- Output register:
  - Single entry.
  - Cleared on wresp_valid_o && wresp_ready_i unless reloaded in the same cycle; back-to-back completions sustain one response per cycle.
  - wresp_o and wresp_valid_o hold stable while valid && !ready.
- Beats arriving while the FIFO is empty are stalled, never dropped.

Optional Feature:
- Macro: SIMMEM_WRESP_LEN_CHECK_EN.
- Defined:
  - A sticky per-burst error flag is set when last=1 arrives with counter != head.burst_length.
  - It is also set when a non-last beat arrives with counter == head.burst_length.
  - The burst still terminates only on last=1.
  - response = error flag (1 = SLVERR); the flag clears on completion.
- Undefined:
  - Burst length is not checked.
  - response is always WRESP_OKAY (0).
  - The flag register is not instantiated.

Decomposition:
- Additions to simmem_pkg:
  - aw_meta_t {id, burst_length}
  - localparam WRESP_OKAY=1'b0, WRESP_SLVERR=1'b1
- Sub-module simmem_wresp_fifo:
  - Generic synchronous FIFO parameterized by width and depth, clk_i/rst_i.
  - Ports: push/pop/full/empty/head.
  - Holds the AW metadata.

Test Plan:
1. Single burst: AW id=0x12, len=3; four W beats with last on the 4th. Required: wresp_valid_o=1 one cycle after the 4th handshake, id=0x12, response=0; exactly one response.
2. Ordering and full FIFO: five AW pushed back-to-back, ids 1..5, len=0, no W. Required: waddr_ready_o=0 after the 4th push. Then send five single-beat bursts: responses carry ids 1,2,3,4,5 in order.
3. Backpressure: wresp_ready_i=0 after a response. Required: wresp_o stable, wdata_ready_o=0 until ready rises. Then ready held high with back-to-back single-beat bursts: one response per cycle.
4. Empty-FIFO stall: W valid with no AW outstanding. Required: wdata_ready_o=0. After AW id=7, len=0 is accepted, the beat is taken the following cycle and id=7 is responded.
5. Reset mid-burst: AW id=9, len=7, three beats, then rst_i for one cycle. Required: no response for id 9, FIFO empty, wresp_valid_o=0.
6. With SIMMEM_WRESP_LEN_CHECK_EN: AW len=3 with last on the 2nd beat gives response=1. A following correct burst gives response=0.
